// File: rtl/alu_pkg.sv
// Shared types for the ALU output stage: op codes, flag record and stage FSM states.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'b0000,
        OP_SUB = 4'b0001,
        OP_AND = 4'b0010,
        OP_OR  = 4'b0011,
        OP_XOR = 4'b0100,
        OP_SLL = 4'b0101,
        OP_SLR = 4'b0110,
        OP_SAR = 4'b0111
    } alu_op_e;

    // Bit order matches the {N,Z,C,V} flag bus.
    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } alu_flags_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b10
    } stage_state_e;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational NZCV generation for a captured ALU result.
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0] y,
    input  logic [3:0]   op,
    input  logic         carry,
    input  logic         ovf,
    output alu_flags_t   flags
);

    // N/Z always come from the result; C/V only carry meaning for the adder ops.
    always_comb begin
        flags   = '0;
        flags.n = y[N-1];
        flags.z = (y == {N{1'b0}});
        case (op)
            OP_ADD, OP_SUB: begin
                flags.c = carry;
                flags.v = ovf;
            end
            default: begin
                flags.c = 1'b0;
                flags.v = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_out_stage.sv
// Registered ALU output stage with NZCV flags and a 2-entry skid buffer on valid/ready.
// Optional sticky overflow tracking is enabled by defining ALU_STICKY_OVF_EN.
module alu_out_stage
    import alu_pkg::*;
#(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] y,
    input  logic [3:0]   ALUControl,
    input  logic         carry_in,
    input  logic         ovf_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_result,
    output logic [3:0]   out_flags
`ifdef ALU_STICKY_OVF_EN
    ,
    input  logic         sticky_clr,
    output logic         sticky_v
`endif
);

    stage_state_e state_r;
    stage_state_e state_nx_s;

    alu_flags_t   flags_s;
    alu_flags_t   main_flags_r;
    alu_flags_t   skid_flags_r;
    logic [N-1:0] main_res_r;
    logic [N-1:0] skid_res_r;
    logic         out_valid_r;
    logic         in_ready_r;

    logic         accept_s;
    logic         drain_s;
    logic         load_main_in_s;
    logic         load_main_skid_s;
    logic         load_skid_s;

    alu_flag_gen #(.N(N)) u_flag_gen (
        .y     (y),
        .op    (ALUControl),
        .carry (carry_in),
        .ovf   (ovf_in),
        .flags (flags_s)
    );

    assign accept_s = in_valid & in_ready_r;
    assign drain_s  = out_valid_r & out_ready;

    // Next-state and load selection; main always holds the oldest entry.
    always_comb begin
        state_nx_s       = state_r;
        load_main_in_s   = 1'b0;
        load_main_skid_s = 1'b0;
        load_skid_s      = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                if (accept_s) begin
                    state_nx_s     = ST_ONE;
                    load_main_in_s = 1'b1;
                end else begin
                    state_nx_s = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (accept_s && !drain_s) begin
                    state_nx_s  = ST_TWO;
                    load_skid_s = 1'b1;
                end else if (accept_s && drain_s) begin
                    state_nx_s     = ST_ONE;
                    load_main_in_s = 1'b1;
                end else if (drain_s) begin
                    state_nx_s = ST_EMPTY;
                end else begin
                    state_nx_s = ST_ONE;
                end
            end
            ST_TWO: begin
                if (drain_s) begin
                    state_nx_s       = ST_ONE;
                    load_main_skid_s = 1'b1;
                end else begin
                    state_nx_s = ST_TWO;
                end
            end
            default: begin
                state_nx_s = ST_EMPTY;
            end
        endcase
    end

    // State register with handshake outputs registered alongside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_EMPTY;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            state_r     <= state_nx_s;
            out_valid_r <= (state_nx_s != ST_EMPTY);
            in_ready_r  <= (state_nx_s != ST_TWO);
        end
    end

    // Main (output-facing) entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_res_r   <= {N{1'b0}};
            main_flags_r <= '0;
        end else if (load_main_in_s) begin
            main_res_r   <= y;
            main_flags_r <= flags_s;
        end else if (load_main_skid_s) begin
            main_res_r   <= skid_res_r;
            main_flags_r <= skid_flags_r;
        end else begin
            main_res_r   <= main_res_r;
            main_flags_r <= main_flags_r;
        end
    end

    // Skid entry, written only when the main entry is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_res_r   <= {N{1'b0}};
            skid_flags_r <= '0;
        end else if (load_skid_s) begin
            skid_res_r   <= y;
            skid_flags_r <= flags_s;
        end else begin
            skid_res_r   <= skid_res_r;
            skid_flags_r <= skid_flags_r;
        end
    end

    assign out_valid  = out_valid_r;
    assign in_ready   = in_ready_r;
    assign out_result = main_res_r;
    assign out_flags  = main_flags_r;

`ifdef ALU_STICKY_OVF_EN
    logic sticky_v_r;

    // A V=1 accept sets the sticky bit even when a clear arrives in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_v_r <= 1'b0;
        end else if (accept_s && flags_s.v) begin
            sticky_v_r <= 1'b1;
        end else if (sticky_clr) begin
            sticky_v_r <= 1'b0;
        end else begin
            sticky_v_r <= sticky_v_r;
        end
    end

    assign sticky_v = sticky_v_r;
`endif

endmodule

// File: tb/tb_alu_out_stage.sv
// Self-checking bench for alu_out_stage: vector table plus scoreboard-driven corner sequences.
module tb_alu_out_stage;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] y;
    logic [3:0] alu_control;
    logic       carry_in;
    logic       ovf_in;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_result;
    logic [3:0] out_flags;
    logic       sticky_clr_b;
    logic       sticky_v_b;
    logic       sticky_m;

    int vectors;
    int miscompares;
    logic [6:0] q[$];

    typedef struct {
        logic [3:0] op;
        logic [2:0] yy;
        logic       c;
        logic       v;
        logic [3:0] exp_flags;
    } vec_t;

    vec_t tbl[12];

    alu_out_stage #(.N(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .y          (y),
        .ALUControl (alu_control),
        .carry_in   (carry_in),
        .ovf_in     (ovf_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags)
`ifdef ALU_STICKY_OVF_EN
        ,
        .sticky_clr (sticky_clr_b),
        .sticky_v   (sticky_v_b)
`endif
    );

`ifndef ALU_STICKY_OVF_EN
    assign sticky_v_b = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] model_flags(logic [2:0] yy, logic [3:0] op, logic c, logic v);
        logic g;
        g = (op == 4'b0000) || (op == 4'b0001);
        return {yy[2], (yy == 3'b000), g & c, g & v};
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive inputs, check current outputs against the occupancy model, advance.
    task automatic step(input logic iv, input logic [2:0] yy, input logic [3:0] op,
                        input logic c, input logic v, input logic [3:0] efl,
                        input logic ordy, input logic clr);
        logic [6:0] e;
        logic acc;
        logic drn;
        logic s_nx;
        in_valid     = iv;
        y            = yy;
        alu_control  = op;
        carry_in     = c;
        ovf_in       = v;
        out_ready    = ordy;
        sticky_clr_b = clr;
        chk("in_ready", {7'd0, in_ready}, {7'd0, (q.size() < 2)});
        chk("out_valid", {7'd0, out_valid}, {7'd0, (q.size() > 0)});
        acc = iv && (q.size() < 2);
        drn = ordy && (q.size() > 0);
        if (drn) begin
            e = q.pop_front();
            chk("out_result", {5'd0, out_result}, {5'd0, e[6:4]});
            chk("out_flags", {4'd0, out_flags}, {4'd0, e[3:0]});
        end
        if (acc) q.push_back({yy, efl});
        s_nx = (acc && efl[0]) ? 1'b1 : (clr ? 1'b0 : sticky_m);
        @(posedge clk);
        #1;
        sticky_m = s_nx;
`ifdef ALU_STICKY_OVF_EN
        chk("sticky_v", {7'd0, sticky_v_b}, {7'd0, sticky_m});
`endif
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 4'd0, ordy, 1'b0);
    endtask

    task automatic send(input logic [2:0] yy, input logic [3:0] op, input logic c,
                        input logic v, input logic ordy);
        step(1'b1, yy, op, c, v, model_flags(yy, op, c, v), ordy, 1'b0);
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        sticky_m     = 1'b0;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        y            = 3'd0;
        alu_control  = 4'd0;
        carry_in     = 1'b0;
        ovf_in       = 1'b0;
        out_ready    = 1'b0;
        sticky_clr_b = 1'b0;

        tbl[0]  = '{4'b0000, 3'b000, 1'b1, 1'b0, 4'b0110};
        tbl[1]  = '{4'b0010, 3'b100, 1'b1, 1'b1, 4'b1000};
        tbl[2]  = '{4'b0001, 3'b111, 1'b0, 1'b1, 4'b1001};
        tbl[3]  = '{4'b0000, 3'b011, 1'b1, 1'b1, 4'b0011};
        tbl[4]  = '{4'b0011, 3'b000, 1'b1, 1'b1, 4'b0100};
        tbl[5]  = '{4'b1000, 3'b101, 1'b1, 1'b1, 4'b1000};
        tbl[6]  = '{4'b1111, 3'b000, 1'b1, 1'b1, 4'b0100};
        tbl[7]  = '{4'b0100, 3'b010, 1'b0, 1'b0, 4'b0000};
        tbl[8]  = '{4'b0111, 3'b110, 1'b1, 1'b1, 4'b1000};
        tbl[9]  = '{4'b0001, 3'b001, 1'b1, 1'b0, 4'b0010};
        tbl[10] = '{4'b0101, 3'b111, 1'b1, 1'b0, 4'b1000};
        tbl[11] = '{4'b0000, 3'b100, 1'b0, 1'b1, 4'b1001};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {7'd0, out_valid}, 8'd0);
        chk("rst_in_ready", {7'd0, in_ready}, 8'd1);
        chk("rst_out_result", {5'd0, out_result}, 8'd0);
        chk("rst_out_flags", {4'd0, out_flags}, 8'd0);
        chk("rst_sticky_v", {7'd0, sticky_v_b}, 8'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back table vectors with a ready sink: one result per cycle.
        for (int i = 0; i < 12; i++)
            step(1'b1, tbl[i].yy, tbl[i].op, tbl[i].c, tbl[i].v, tbl[i].exp_flags, 1'b1, 1'b0);
        idle(1'b1);

        // Stalled sink: third item must wait until the skid drains, order preserved.
        send(3'd1, 4'b0000, 1'b0, 1'b0, 1'b0);
        send(3'd2, 4'b0000, 1'b0, 1'b0, 1'b0);
        send(3'd3, 4'b0000, 1'b0, 1'b0, 1'b0);
        send(3'd3, 4'b0000, 1'b0, 1'b0, 1'b0);
        send(3'd3, 4'b0000, 1'b0, 1'b0, 1'b1);
        send(3'd3, 4'b0000, 1'b0, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Ten back-to-back random results with simultaneous accept and drain.
        for (int i = 0; i < 10; i++)
            send(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Sticky overflow: set by SUB ovf, survives ADD without ovf, then cleared.
        send(3'd5, 4'b0001, 1'b0, 1'b1, 1'b1);
        send(3'd2, 4'b0000, 1'b0, 1'b0, 1'b1);
        idle(1'b1);
        step(1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        idle(1'b1);
        // Set wins over a simultaneous clear.
        step(1'b1, 3'd1, 4'b0000, 1'b1, 1'b1, model_flags(3'd1, 4'b0000, 1'b1, 1'b1), 1'b1, 1'b1);
        step(1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        idle(1'b1);

        // Asynchronous reset while both entries are full.
        send(3'd5, 4'b0000, 1'b1, 1'b1, 1'b0);
        send(3'd6, 4'b0001, 1'b1, 1'b1, 1'b0);
        chk("two_in_ready", {7'd0, in_ready}, 8'd0);
        in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {7'd0, out_valid}, 8'd0);
        chk("arst_in_ready", {7'd0, in_ready}, 8'd1);
        chk("arst_out_flags", {4'd0, out_flags}, 8'd0);
        chk("arst_out_result", {5'd0, out_result}, 8'd0);
        chk("arst_sticky_v", {7'd0, sticky_v_b}, 8'd0);
        q.delete();
        sticky_m = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // First post-reset accept behaves as from EMPTY.
        send(3'd6, 4'b0000, 1'b1, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);
        chk("final_empty", {7'd0, out_valid}, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
